// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// UART_TX_PARITY_EN adds one parity bit per frame.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Bit-period counter width covers CLKS_PER_BIT up to 65535.
  localparam int CNT_W = 16;
  // Payload index width covers DATA_BITS up to 8.
  localparam int IDX_W = 3;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int stop_bits);
    return (1 + data_bits + PARITY_BITS + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Reloadable down counter that marks the end of each serial bit period.
module uart_baud_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over counting so a tick reloads in the same cycle it fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bits.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 bit_tick,
  output tx_state_t            dbg_state
);

  // Handshake: a byte is taken on any rising edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE outside reset, and tx_data is sampled only then.

  localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, DATA_BITS, STOP_BITS);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      FRAME_CYCLES > 12 * 65535) begin : g_bad_params
    $error("uart_tx_ctrl: illegal parameter set");
  end

  tx_state_t            state;
  tx_state_t            next_state;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 accept;
  logic                 cnt_zero;
  logic                 last_data;
  logic                 last_stop;

  assign tx_ready  = (state == ST_IDLE) && !rst;
  assign accept    = tx_valid && tx_ready;
  assign bit_tick  = cnt_zero && (state != ST_IDLE);
  assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  uart_baud_cnt #(
    .W(CNT_W)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || bit_tick),
    .en       (state != ST_IDLE),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_START;
      ST_START: if (bit_tick) next_state = ST_DATA;
      ST_DATA: begin
        if (bit_tick && last_data) begin
`ifdef UART_TX_PARITY_EN
          next_state = ST_PARITY;
`else
          next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_tick) next_state = ST_STOP;
`endif
      ST_STOP:  if (bit_tick && last_stop) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Payload shifts right so txd always presents shift_q[0] during DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (accept) begin
        shift_q <= tx_data;
      end else if ((state == ST_DATA) && bit_tick) begin
        shift_q <= shift_q >> 1;
      end
      if ((state == ST_DATA) && bit_tick) begin
        bit_idx <= last_data ? '0 : bit_idx + 1'b1;
      end
      if ((state == ST_STOP) && bit_tick) begin
        stop_idx <= last_stop ? 1'b0 : 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Parity is taken from the whole payload at accept, before shifting destroys it.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= (^tx_data) ^ 1'(PARITY_ODD);
    end
  end
`endif

  always_comb begin
    txd = 1'b1;
    case (state)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd = parity_q;
`endif
      default:   txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl (CLKS_PER_BIT=4, DATA_BITS=8), optionally with UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL1 = (1 + 8 + PB + 1) * CPB;
  localparam int FL2 = (1 + 8 + PB + 2) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       r1, txd1, busy1, tick1;
  tx_state_t  st1;

  logic       v2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       r2, txd2, busy2, tick2;
  tx_state_t  st2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
    .txd(txd1), .busy(busy1), .bit_tick(tick1), .dbg_state(st1)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut_stop2 (
    .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(r2),
    .txd(txd2), .busy(busy2), .bit_tick(tick2), .dbg_state(st2)
  );

`ifdef UART_TX_PARITY_EN
  logic       v3 = 1'b0;
  logic [7:0] d3 = 8'h00;
  logic       r3, txd3, busy3, tick3;
  tx_state_t  st3;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(d3), .tx_valid(v3), .tx_ready(r3),
    .txd(txd3), .busy(busy3), .bit_tick(tick3), .dbg_state(st3)
  );
`endif

  // Expected line level for bit slot idx of a frame (0 = start); slots past payload are high.
  function automatic logic frame_bit(input logic [7:0] d, input int idx, input logic odd);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PB == 1 && idx == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready1();
    int n;
    n = 0;
    while (r1 !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_cmp++;
    if (r1 !== 1'b1) begin
      n_err++;
      $display("FAIL wait_ready1: tx_ready=%b after %0d cycles, required 1", r1, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (r1 !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", r1); end
    n_cmp++; if (txd1 !== 1'b1) begin n_err++; $display("FAIL rst_txd: got %b want 1", txd1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy1); end
    n_cmp++; if (tick1 !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", tick1); end
    n_cmp++; if (st1 !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", st1, ST_IDLE); end
    rst = 1'b0;
    step();
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL rel_ready: got %b want 1", r1); end
    n_cmp++; if (r2 !== 1'b1) begin n_err++; $display("FAIL rel_ready2: got %b want 1", r2); end
  endtask

  task automatic test_send_a5();
    logic [10:0] seq;
    int b;
`ifdef UART_TX_PARITY_EN
    seq = 11'b10101001010;
`else
    seq = 11'b11101001010;
`endif
    wait_ready1();
    d1 = 8'hA5;
    v1 = 1'b1;
    step();
    v1 = 1'b0;
    d1 = 8'h00;
    n_cmp++; if (st1 !== ST_START) begin n_err++; $display("FAIL a5_start_state: got %0d want %0d", st1, ST_START); end
    for (int i = 1; i <= FL1; i++) begin
      b = (i - 1) / CPB;
      n_cmp++;
      if (txd1 !== seq[b]) begin n_err++; $display("FAIL a5_txd cyc %0d: got %b want %b", i, txd1, seq[b]); end
      n_cmp++;
      if (tick1 !== ((i % CPB) == 0)) begin n_err++; $display("FAIL a5_tick cyc %0d: got %b want %b", i, tick1, (i % CPB) == 0); end
      n_cmp++;
      if (r1 !== 1'b0) begin n_err++; $display("FAIL a5_ready_early cyc %0d: got %b want 0", i, r1); end
      step();
    end
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL a5_ready_return: got %b want 1", r1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL a5_busy_end: got %b want 0", busy1); end
  endtask

  task automatic test_back_to_back();
    logic exp;
    int acc2;
    acc2 = -1;
    wait_ready1();
    d1 = 8'h00;
    v1 = 1'b1;
    step();
    d1 = 8'hFF;
    for (int i = 1; i <= 2 * FL1 + 1; i++) begin
      if (i == FL1 + 2) v1 = 1'b0;
      if (i <= FL1) exp = frame_bit(8'h00, (i - 1) / CPB, 1'b0);
      else if (i == FL1 + 1) exp = 1'b1;
      else exp = frame_bit(8'hFF, (i - FL1 - 2) / CPB, 1'b0);
      n_cmp++;
      if (txd1 !== exp) begin n_err++; $display("FAIL b2b_txd cyc %0d: got %b want %b", i, txd1, exp); end
      n_cmp++;
      if (r1 !== (i == FL1 + 1)) begin n_err++; $display("FAIL b2b_ready cyc %0d: got %b want %b", i, r1, i == FL1 + 1); end
      if (r1 === 1'b1 && v1 === 1'b1 && acc2 < 0) acc2 = i;
      step();
    end
    n_cmp++; if (acc2 !== FL1 + 1) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", acc2, FL1 + 1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b want 0", busy1); end
  endtask

  task automatic test_mid_reset();
    wait_ready1();
    d1 = 8'h00;
    v1 = 1'b1;
    step();
    v1 = 1'b0;
    repeat (8) step();
    n_cmp++; if (txd1 !== 1'b0) begin n_err++; $display("FAIL mrst_pre_txd: got %b want 0", txd1); end
    rst = 1'b1;
    v1 = 1'b1;
    step();
    n_cmp++; if (txd1 !== 1'b1) begin n_err++; $display("FAIL mrst_txd: got %b want 1", txd1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b want 0", busy1); end
    n_cmp++; if (r1 !== 1'b0) begin n_err++; $display("FAIL mrst_ready: got %b want 0", r1); end
    n_cmp++; if (tick1 !== 1'b0) begin n_err++; $display("FAIL mrst_tick: got %b want 0", tick1); end
    step();
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mrst_accept_dropped: busy got %b want 0", busy1); end
    rst = 1'b0;
    v1 = 1'b0;
    step();
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL mrst_ready_after: got %b want 1", r1); end
    n_cmp++; if (st1 !== ST_IDLE) begin n_err++; $display("FAIL mrst_state_after: got %0d want %0d", st1, ST_IDLE); end
  endtask

  task automatic test_data_change();
    logic [7:0] cap;
    int ticks;
    int b;
    cap = 8'h00;
    ticks = 0;
    wait_ready1();
    d1 = 8'h3C;
    v1 = 1'b1;
    step();
    v1 = 1'b0;
    for (int i = 1; i <= FL1; i++) begin
      d1 = 8'(i * 37);
      if (i == 10) v1 = 1'b1;
      if (i == 12) v1 = 1'b0;
      b = (i - 1) / CPB;
      if ((i % CPB) == 2 && b >= 1 && b <= 8) cap[b-1] = txd1;
      if (tick1 === 1'b1) ticks++;
      step();
    end
    n_cmp++; if (cap !== 8'h3C) begin n_err++; $display("FAIL chg_byte: got %02h want 3c", cap); end
    n_cmp++; if (ticks !== FL1 / CPB) begin n_err++; $display("FAIL chg_ticks: got %0d want %0d", ticks, FL1 / CPB); end
    step();
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL chg_no_reaccept: busy got %b want 0", busy1); end
  endtask

  task automatic test_parity();
    logic exp1;
    logic exp3;
    wait_ready1();
    d1 = 8'h07;
    v1 = 1'b1;
`ifdef UART_TX_PARITY_EN
    d3 = 8'h07;
    v3 = 1'b1;
`endif
    step();
    v1 = 1'b0;
`ifdef UART_TX_PARITY_EN
    v3 = 1'b0;
`endif
    for (int i = 1; i <= FL1; i++) begin
      if ((i - 1) / CPB == 9) begin
        exp1 = 1'b1;
`ifdef UART_TX_PARITY_EN
        exp3 = 1'b0;
`else
        exp3 = 1'b1;
`endif
      end else begin
        exp1 = frame_bit(8'h07, (i - 1) / CPB, 1'b0);
        exp3 = exp1;
      end
      n_cmp++;
      if (txd1 !== exp1) begin n_err++; $display("FAIL par_even_txd cyc %0d: got %b want %b", i, txd1, exp1); end
`ifdef UART_TX_PARITY_EN
      n_cmp++;
      if (txd3 !== exp3) begin n_err++; $display("FAIL par_odd_txd cyc %0d: got %b want %b", i, txd3, exp3); end
`endif
      if (i == FL1) begin
        n_cmp++;
        if (r1 !== 1'b0) begin n_err++; $display("FAIL par_ready_early: got %b want 0", r1); end
      end
      step();
    end
    n_cmp++; if (r1 !== 1'b1) begin n_err++; $display("FAIL par_frame_len: ready got %b want 1 at %0d", r1, FL1 + 1); end
  endtask

  task automatic test_stop2();
    logic exp;
    int high_run;
    high_run = 0;
    d2 = 8'h55;
    v2 = 1'b1;
    step();
    v2 = 1'b0;
    for (int i = 1; i <= FL2; i++) begin
      exp = frame_bit(8'h55, (i - 1) / CPB, 1'b0);
      n_cmp++;
      if (txd2 !== exp) begin n_err++; $display("FAIL s2_txd cyc %0d: got %b want %b", i, txd2, exp); end
      n_cmp++;
      if (r2 !== 1'b0) begin n_err++; $display("FAIL s2_ready_early cyc %0d: got %b want 0", i, r2); end
      if (i > CPB * (9 + PB) && txd2 === 1'b1) high_run++;
      step();
    end
    n_cmp++; if (high_run !== 2 * CPB) begin n_err++; $display("FAIL s2_stop_len: got %0d want %0d", high_run, 2 * CPB); end
    n_cmp++; if (r2 !== 1'b1) begin n_err++; $display("FAIL s2_frame_len: ready got %b want 1", r2); end
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL s2_busy_end: got %b want 0", busy2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send_a5();
    test_back_to_back();
    test_mid_reset();
    test_data_change();
    test_parity();
    test_stop2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..8).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning parity sense (0 even, 1 odd); used only when UART_TX_PARITY_EN is defined.
REQ-005 SHALL have port clk, input, 1, system clock; all state SHALL be updated on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port tx_data, input, DATA_BITS, payload, sampled only on accept.
REQ-008 SHALL have port tx_valid, input, 1, requester offers tx_data.
REQ-009 SHALL have port tx_ready, output, 1, block can accept a byte this cycle.
REQ-010 SHALL have port txd, output, 1, serial line, idle high.
REQ-011 SHALL have port busy, output, 1, frame in progress.
REQ-012 SHALL have port bit_tick, output, 1, one-cycle pulse at the end of each bit period; low when idle.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when UART_TX_PARITY_EN is defined.
REQ-014 SHALL accept a byte when tx_valid && tx_ready; tx_ready SHALL be high only in IDLE.
REQ-015 SHALL latch tx_data into a shift register on accept, move to START in the next cycle, and drive txd low in the cycle after accept.
REQ-016 SHALL reload the bit counter to CLKS_PER_BIT-1 on accept and on every bit_tick, so each bit lasts exactly CLKS_PER_BIT cycles, including the first.
REQ-017 SHALL assert bit_tick when the counter equals 0 in a non-IDLE state, and SHALL advance the FSM only on bit_tick.
REQ-018 SHALL send data LSB first in DATA, shifting once per bit_tick, and SHALL leave DATA after DATA_BITS ticks, tracked by a bit index that wraps to 0.
REQ-019 SHALL drive txd high in STOP for STOP_BITS bit periods, then return to IDLE.
REQ-020 SHALL keep a full frame at (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P is 1 with parity and 0 without.
REQ-021 SHALL assert tx_ready in the cycle after the final stop tick, so back-to-back frames have zero idle bit-time between stop and the next start, excluding the one accept cycle.
REQ-022 SHALL ignore tx_valid and any change in tx_data while busy.
REQ-023 SHALL hold busy = (state != IDLE).

Reset
REQ-024 SHALL, on rst, force state IDLE, txd=1, tx_ready=1 after release (0 during reset), busy=0, bit_tick=0, counter=0, bit index=0, and shift register=0.
REQ-025 SHALL abort a frame when rst is asserted mid-frame; txd SHALL be high in the cycle after rst is sampled.
REQ-026 SHALL give rst priority over an accept in the same cycle; the byte is dropped.

Configuration
REQ-027 SHALL, with macro UART_TX_PARITY_EN defined, insert one PARITY bit after DATA equal to XOR(payload) XOR PARITY_ODD.
REQ-028 SHALL, without UART_TX_PARITY_EN, go directly from DATA to STOP and contain no parity logic.

Structure
REQ-029 SHALL take the state encoding typedef, and the frame-length helper constant, from shared package uart_pkg.
REQ-030 SHALL instantiate one sub-module, uart_baud_cnt, that provides the reloadable down counter with load, enable and zero-flag outputs.

Verification (bench uses CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1)
REQ-031 SHALL cover this scenario: send 0xA5 without parity. Required response: txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_ready returns after 40 cycles.
REQ-032 SHALL cover this scenario: tx_valid held high with 0x00 then 0xFF. Required response: two frames 41 cycles apart from accept to accept; no glitch on txd between frames.
REQ-033 SHALL cover this scenario: UART_TX_PARITY_EN defined, send 0x07. Required response: parity bit 1 for even (PARITY_ODD=0) and 0 for odd; frame is 44 cycles.
REQ-034 SHALL cover this scenario: rst asserted at cycle 10 of a frame. Required response: txd=1 and busy=0 in the next cycle; tx_ready=1 after rst is released.
REQ-035 SHALL cover this scenario: tx_data changed while busy. Required response: the transmitted byte equals the accepted value; bit_tick pulses exactly 10 times per frame.
REQ-036 SHALL cover this scenario: STOP_BITS=2, send 0x55. Required response: txd is high for 8 cycles after the last data bit; the frame is 44 cycles.
